// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM controller slice:
//   - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
//   - arbiter state encoding
//   - idle bank/address values driven on the pins between grants
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_MRS       = 4'b0000;

    localparam logic [1:0]  IDLE_BANK = 2'b11;
    localparam logic [12:0] IDLE_ADDR = 13'h1FFF;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

endpackage : sdram_pkg

// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
// Owns the SDRAM command/address/data pins and hands them to one requester at
// a time: the init sequencer until init completes, then auto-refresh, write
// and read engines. Refresh has top priority; simultaneous write and read
// requests alternate. A NOP cycle (ARBIT state) always separates two grants.
// A grant that runs TIMEOUT cycles past entry without its *_end is forcibly
// released and flags a sticky timeout_err.
//
// Ports:
//   clk, rst                      controller clock, synchronous active-high reset
//   init_end, init_cmd/bank/addr  init sequencer status and pin values
//   aref_req/end/cmd/bank/addr    refresh engine request, done pulse, pin values
//   wr_req/end/cmd/bank/addr      write engine request, done pulse, pin values
//   wr_sdram_en, wr_sdram_data    write engine DQ drive enable and data
//   rd_req/end/cmd/bank/addr      read engine request, done pulse, pin values
//   aref_en, wr_en, rd_en         grants, decoded from the state register
//   aref_pending                  refresh waiting while a write/read is granted
//   sdram_cmd/bank/addr           SDRAM command pins
//   sdram_dq_oe, sdram_dq_out     DQ tristate control and output data
//   timeout_err                   sticky grant-timeout flag
// -----------------------------------------------------------------------------
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [1:0]        init_bank,
    input  logic [12:0]       init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [1:0]        aref_bank,
    input  logic [12:0]       aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [1:0]        wr_bank,
    input  logic [12:0]       wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [1:0]        rd_bank,
    input  logic [12:0]       rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              aref_pending,
    output logic [3:0]        sdram_cmd,
    output logic [1:0]        sdram_bank,
    output logic [12:0]       sdram_addr,
    output logic              sdram_dq_oe,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              timeout_err
);

    localparam int             CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic             r_last_wr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;

    logic w_in_grant;
    logic w_grant_end;
    logic w_timeout;

    assign w_in_grant = (r_state == ST_AREF) || (r_state == ST_WRITE) || (r_state == ST_READ);
    // Only the granted source's end pulse counts; stray pulses are ignored.
    assign w_grant_end = ((r_state == ST_AREF)  && aref_end) ||
                         ((r_state == ST_WRITE) && wr_end)   ||
                         ((r_state == ST_READ)  && rd_end);
    assign w_timeout = w_in_grant && (r_cnt == TIMEOUT_C);

    // ---------------------------------------------------------------------
    // State register plus the small amount of bookkeeping that rides on it
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_INIT;
            r_last_wr     <= 1'b0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (r_state == ST_ARBIT) begin
                if (w_state_next == ST_WRITE)
                    r_last_wr <= 1'b1;
                else if (w_state_next == ST_READ)
                    r_last_wr <= 1'b0;
            end

            // Grants are always entered from ARBIT where the count is zero,
            // so holding the same state is the only case that counts up.
            if (w_in_grant && (w_state_next == r_state))
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;

            // End on the timeout cycle is a normal completion.
            if (w_timeout && !w_grant_end)
                r_timeout_err <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: begin
                if (init_end)
                    w_state_next = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (aref_req)
                    w_state_next = ST_AREF;
                else if (wr_req && rd_req)
                    w_state_next = r_last_wr ? ST_READ : ST_WRITE;
                else if (wr_req)
                    w_state_next = ST_WRITE;
                else if (rd_req)
                    w_state_next = ST_READ;
            end
            ST_AREF, ST_WRITE, ST_READ: begin
                if (w_grant_end || w_timeout)
                    w_state_next = ST_ARBIT;
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output logic: grants and the pin mux
    // ---------------------------------------------------------------------
    always_comb begin
        aref_en    = (r_state == ST_AREF);
        wr_en      = (r_state == ST_WRITE);
        rd_en      = (r_state == ST_READ);
        sdram_cmd  = CMD_NOP;
        sdram_bank = IDLE_BANK;
        sdram_addr = IDLE_ADDR;
        case (r_state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_bank = init_bank;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_bank = aref_bank;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_bank = wr_bank;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_bank = IDLE_BANK;
                sdram_addr = IDLE_ADDR;
            end
        endcase
    end

    assign aref_pending = aref_req && ((r_state == ST_WRITE) || (r_state == ST_READ));
    // DQ is driven only while the write engine holds the grant, so a stuck
    // wr_sdram_en cannot fight the SDRAM during reads.
    assign sdram_dq_oe  = wr_sdram_en && (r_state == ST_WRITE);
    assign sdram_dq_out = wr_sdram_data;
    assign timeout_err  = r_timeout_err;

endmodule : sdram_arbit

// File: tb/tb_sdram_arbit.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbit
// Directed bench for sdram_arbit (TIMEOUT=8). Inputs change 1 ns after a
// rising edge and outputs are checked at that same point, so every check sees
// the state registered on the preceding edge.
// -----------------------------------------------------------------------------
module tb_sdram_arbit;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [1:0]        init_bank;
    logic [12:0]       init_addr;
    logic              aref_req, aref_end;
    logic [3:0]        aref_cmd;
    logic [1:0]        aref_bank;
    logic [12:0]       aref_addr;
    logic              wr_req, wr_end;
    logic [3:0]        wr_cmd;
    logic [1:0]        wr_bank;
    logic [12:0]       wr_addr;
    logic              wr_sdram_en;
    logic [DATA_W-1:0] wr_sdram_data;
    logic              rd_req, rd_end;
    logic [3:0]        rd_cmd;
    logic [1:0]        rd_bank;
    logic [12:0]       rd_addr;
    logic              aref_en, wr_en, rd_en, aref_pending;
    logic [3:0]        sdram_cmd;
    logic [1:0]        sdram_bank;
    logic [12:0]       sdram_addr;
    logic              sdram_dq_oe;
    logic [DATA_W-1:0] sdram_dq_out;
    logic              timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sdram_arbit #(
        .TIMEOUT (8),
        .DATA_W  (DATA_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .init_end      (init_end),
        .init_cmd      (init_cmd),
        .init_bank     (init_bank),
        .init_addr     (init_addr),
        .aref_req      (aref_req),
        .aref_end      (aref_end),
        .aref_cmd      (aref_cmd),
        .aref_bank     (aref_bank),
        .aref_addr     (aref_addr),
        .wr_req        (wr_req),
        .wr_end        (wr_end),
        .wr_cmd        (wr_cmd),
        .wr_bank       (wr_bank),
        .wr_addr       (wr_addr),
        .wr_sdram_en   (wr_sdram_en),
        .wr_sdram_data (wr_sdram_data),
        .rd_req        (rd_req),
        .rd_end        (rd_end),
        .rd_cmd        (rd_cmd),
        .rd_bank       (rd_bank),
        .rd_addr       (rd_addr),
        .aref_en       (aref_en),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .aref_pending  (aref_pending),
        .sdram_cmd     (sdram_cmd),
        .sdram_bank    (sdram_bank),
        .sdram_addr    (sdram_addr),
        .sdram_dq_oe   (sdram_dq_oe),
        .sdram_dq_out  (sdram_dq_out),
        .timeout_err   (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grants packed as {aref_en, wr_en, rd_en}; pins as {cmd, bank, addr}.
    task automatic chk_state(input string tag, input logic [2:0] grants,
                             input logic [3:0] cmd, input logic [1:0] bank,
                             input logic [12:0] addr);
        chk({tag, ".grant"}, {29'd0, aref_en, wr_en, rd_en}, {29'd0, grants});
        chk({tag, ".pins"},  {13'd0, sdram_cmd, sdram_bank, sdram_addr},
                             {13'd0, cmd, bank, addr});
        $display("cyc %s: grants=%b cmd=%b bank=%b addr=%h oe=%b terr=%b", tag,
                 {aref_en, wr_en, rd_en}, sdram_cmd, sdram_bank, sdram_addr,
                 sdram_dq_oe, timeout_err);
    endtask

    initial begin
        rst = 1'b1; init_end = 1'b0;
        init_cmd = 4'b0000; init_bank = 2'b01; init_addr = 13'h0123;
        aref_req = 1'b0; aref_end = 1'b0;
        aref_cmd = 4'b0001; aref_bank = 2'b10; aref_addr = 13'h0AAA;
        wr_req = 1'b0; wr_end = 1'b0;
        wr_cmd = 4'b0100; wr_bank = 2'b00; wr_addr = 13'h0111;
        wr_sdram_en = 1'b1; wr_sdram_data = 16'hBEEF;   // enable held high throughout
        rd_req = 1'b0; rd_end = 1'b0;
        rd_cmd = 4'b0101; rd_bank = 2'b01; rd_addr = 13'h0222;

        // Reset: INIT, pins follow init source, no grants, DQ off.
        repeat (3) tick();
        chk_state("reset", 3'b000, 4'b0000, 2'b01, 13'h0123);
        chk("reset.oe",   {31'd0, sdram_dq_oe}, 32'd0);
        chk("reset.terr", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;

        // Stay in INIT until init_end (raised at cycle 20).
        repeat (17) tick();
        chk_state("init_wait", 3'b000, 4'b0000, 2'b01, 13'h0123);
        init_end = 1'b1;
        tick();
        chk_state("arbit_idle", 3'b000, 4'b0111, 2'b11, 13'h1FFF);
        init_end = 1'b0;                // dropping init_end must be ignored
        tick();
        chk_state("arbit_hold", 3'b000, 4'b0111, 2'b11, 13'h1FFF);

        // All three request: refresh wins.
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        chk_state("aref_grant", 3'b100, 4'b0001, 2'b10, 13'h0AAA);
        chk("aref.oe", {31'd0, sdram_dq_oe}, 32'd0);
        chk("aref.pend", {31'd0, aref_pending}, 32'd0);
        rd_end = 1'b1;                  // stray end from non-granted source
        tick();
        chk_state("aref_stray_end", 3'b100, 4'b0001, 2'b10, 13'h0AAA);
        rd_end = 1'b0; aref_req = 1'b0; aref_end = 1'b1;
        tick();
        chk_state("aref_done", 3'b000, 4'b0111, 2'b11, 13'h1FFF);
        aref_end = 1'b0;
        tick();
        // last_wr is 0 after reset, so the tie goes to WRITE.
        chk_state("wr_grant", 3'b010, 4'b0100, 2'b00, 13'h0111);
        chk("wr.oe",   {31'd0, sdram_dq_oe}, 32'd1);
        chk("wr.data", {16'd0, sdram_dq_out}, 32'h0000BEEF);
        wr_end = 1'b1;
        tick();
        chk_state("wr_done", 3'b000, 4'b0111, 2'b11, 13'h1FFF);
        chk("wr_done.oe", {31'd0, sdram_dq_oe}, 32'd0);
        wr_end = 1'b0;
        tick();
        chk_state("rd_alt", 3'b001, 4'b0101, 2'b01, 13'h0222);
        chk("rd.oe", {31'd0, sdram_dq_oe}, 32'd0);
        rd_end = 1'b1;
        tick();
        chk_state("rd_done", 3'b000, 4'b0111, 2'b11, 13'h1FFF);
        rd_end = 1'b0;
        tick();
        chk_state("wr_alt", 3'b010, 4'b0100, 2'b00, 13'h0111);

        // Refresh arrives mid-write: hint only, no preemption.
        rd_req = 1'b0; aref_req = 1'b1;
        tick();
        chk_state("wr_pend", 3'b010, 4'b0100, 2'b00, 13'h0111);
        chk("wr_pend.pend", {31'd0, aref_pending}, 32'd1);
        wr_req = 1'b0; wr_end = 1'b1;
        tick();
        chk_state("wr_pend_done", 3'b000, 4'b0111, 2'b11, 13'h1FFF);
        chk("arbit.pend", {31'd0, aref_pending}, 32'd0);
        wr_end = 1'b0;
        tick();
        chk_state("aref_after_wr", 3'b100, 4'b0001, 2'b10, 13'h0AAA);
        aref_req = 1'b0; aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        chk_state("aref2_done", 3'b000, 4'b0111, 2'b11, 13'h1FFF);

        // Timeout: write with no wr_end. Counter is 0 on the first grant
        // cycle, reaches 8 on the ninth, and the grant drops on the next edge.
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        chk_state("to_grant", 3'b010, 4'b0100, 2'b00, 13'h0111);
        repeat (8) tick();
        chk_state("to_last", 3'b010, 4'b0100, 2'b00, 13'h0111);
        chk("to_last.terr", {31'd0, timeout_err}, 32'd0);
        tick();
        chk_state("to_drop", 3'b000, 4'b0111, 2'b11, 13'h1FFF);
        chk("to_drop.terr", {31'd0, timeout_err}, 32'd1);
        repeat (3) tick();
        chk("to_sticky.terr", {31'd0, timeout_err}, 32'd1);

        // Reset in the middle of a read.
        rd_req = 1'b1;
        tick();
        chk_state("rd_pre_rst", 3'b001, 4'b0101, 2'b01, 13'h0222);
        rst = 1'b1;
        tick();
        chk_state("rst_mid_rd", 3'b000, 4'b0000, 2'b01, 13'h0123);
        chk("rst_mid_rd.oe",   {31'd0, sdram_dq_oe}, 32'd0);
        chk("rst_mid_rd.terr", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;
        tick();
        chk_state("rst_stay_init", 3'b000, 4'b0000, 2'b01, 13'h0123);

        // rd_end on exactly the timeout cycle is a normal completion.
        init_end = 1'b1;
        tick();
        init_end = 1'b0;
        tick();
        rd_req = 1'b0;
        chk_state("rd_edge_grant", 3'b001, 4'b0101, 2'b01, 13'h0222);
        repeat (8) tick();
        chk_state("rd_edge_last", 3'b001, 4'b0101, 2'b01, 13'h0222);
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        chk_state("rd_edge_done", 3'b000, 4'b0111, 2'b11, 13'h1FFF);
        chk("rd_edge.terr", {31'd0, timeout_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sdram_arbit
